// File: rtl/iob_cpu_bus_split_pkg.sv
// rtl/iob_cpu_bus_split_pkg.sv - FSM states, error codes and slave-select decode
// Shared by iob_cpu_bus_split and its watchdog.
package iob_cpu_bus_split_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DECODE  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Slave index for a new request. Fetches during boot go to the boot slave;
  // everything else uses the zero-extended address MSBs.
  function automatic logic [31:0] sel_decode(input logic        redirect,
                                             input logic [31:0] boot_slv,
                                             input logic [31:0] addr_sel);
    return redirect ? boot_slv : addr_sel;
  endfunction

endpackage

// File: rtl/iob_cpu_bus_split_watchdog.sv
// rtl/iob_cpu_bus_split_watchdog.sv - wait-cycle counter with expiry strobe
// Ports: clk, rst (async, active-high), clr (zero the count), en (count this
// cycle), expired (en is high on the 2**TIMEOUT_W-1'th enabled cycle).
module iob_cpu_bus_split_watchdog #(
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Expiry is flagged while the count sits one below all-ones, so the
  // counter reaches all-ones on the same edge that the FSM gives up.
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TIMEOUT_W'(1);
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/iob_cpu_bus_split.sv
// rtl/iob_cpu_bus_split.sv - CPU native port to N iob slave buses splitter
// CPU side : cpu_valid/instr/addr/wdata/wstrb in, cpu_rdata/cpu_ready out.
// Slave side: m_valid (one-hot pulse), m_addr/m_wdata/m_wstrb broadcast,
//             m_rdata/m_ready per slave.
// Status   : err (sticky), err_code (last error), err_clr (sync clear).
// Control  : clk, rst (async, active-high), boot (fetch redirect).
module iob_cpu_bus_split
  import iob_cpu_bus_split_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                N_SLAVES  = 2,
  parameter int                SEL_W     = 1,
  parameter int                BOOT_SLV  = 1,
  parameter int                TIMEOUT_W = 8,
  parameter logic [DATA_W-1:0] ERR_DATA  = {DATA_W{1'b1}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       boot,
  input  logic                       cpu_valid,
  input  logic                       cpu_instr,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  input  logic [DATA_W/8-1:0]        cpu_wstrb,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       cpu_ready,
  output logic [N_SLAVES-1:0]        m_valid,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W/8-1:0]        m_wstrb,
  input  logic [N_SLAVES*DATA_W-1:0] m_rdata,
  input  logic [N_SLAVES-1:0]        m_ready,
  output logic                       err,
  output logic [1:0]                 err_code,
  input  logic                       err_clr
);

  state_t              state;
  logic [N_SLAVES-1:0] sel_oh;
  logic                dec_err;
  logic [31:0]         addr_sel;
  logic [31:0]         sel_idx;
  logic [N_SLAVES-1:0] req_oh;
  logic                hit;
  logic [DATA_W-1:0]   hit_rdata;
  logic                wd_expired;

  // Decode of the incoming request; an out-of-range index yields an empty
  // one-hot, which doubles as the decode-error indication.
  always_comb begin
    addr_sel              = '0;
    addr_sel[SEL_W-1:0]   = cpu_addr[ADDR_W-1 -: SEL_W];
    sel_idx               = sel_decode(boot & cpu_instr, 32'(BOOT_SLV), addr_sel);
    req_oh                = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      req_oh[i] = (sel_idx == 32'(i));
    end
  end

  // Only the latched slave can complete the transaction.
  assign hit = |(m_ready & sel_oh);

  always_comb begin
    hit_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_oh[i]) begin
        hit_rdata = hit_rdata | m_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  iob_cpu_bus_split_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == REQ),
    .en      (state == WAIT),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel_oh    <= '0;
      dec_err   <= 1'b0;
      m_valid   <= '0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      m_valid   <= '0;
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_valid) begin
            m_addr  <= cpu_addr;
            m_wdata <= cpu_wdata;
            m_wstrb <= cpu_wstrb;
            sel_oh  <= req_oh;
            dec_err <= ~|req_oh;
            m_valid <= req_oh;
            state   <= REQ;
          end
        end
        // A decode error still spends the request slot (with no pulse), so
        // every response arrives at least two cycles after acceptance.
        REQ: begin
          if (dec_err) begin
            cpu_ready <= 1'b1;
            cpu_rdata <= ERR_DATA;
            err       <= 1'b1;
            err_code  <= ERR_DECODE;
            state     <= RESP;
          end else if (hit) begin
            cpu_ready <= 1'b1;
            cpu_rdata <= hit_rdata;
            state     <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        // Ready is tested first so a response landing on the expiry cycle
        // is delivered rather than reported as a timeout.
        WAIT: begin
          if (hit) begin
            cpu_ready <= 1'b1;
            cpu_rdata <= hit_rdata;
            state     <= RESP;
          end else if (wd_expired) begin
            cpu_ready <= 1'b1;
            cpu_rdata <= ERR_DATA;
            err       <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (err_clr) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_iob_cpu_bus_split.sv
// tb/tb_iob_cpu_bus_split.sv - vector table and scoreboard bench for iob_cpu_bus_split
`timescale 1ns/1ps
module tb_iob_cpu_bus_split;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // DUT A: default configuration (2 slaves, 1 select bit, 8-bit watchdog)
  logic        boot, cpu_valid, cpu_instr, err_clr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic [1:0]  m_valid;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [63:0] m_rdata;
  logic [1:0]  m_ready;
  logic        err;
  logic [1:0]  err_code;

  // DUT B: 3 slaves, 2 select bits, short watchdog
  logic        b_boot, b_cpu_valid, b_cpu_instr, b_err_clr;
  logic [31:0] b_cpu_addr, b_cpu_wdata;
  logic [3:0]  b_cpu_wstrb;
  logic [31:0] b_cpu_rdata;
  logic        b_cpu_ready;
  logic [2:0]  b_m_valid;
  logic [31:0] b_m_addr, b_m_wdata;
  logic [3:0]  b_m_wstrb;
  logic [95:0] b_m_rdata;
  logic [2:0]  b_m_ready;
  logic        b_err;
  logic [1:0]  b_err_code;

  iob_cpu_bus_split dut_a (
    .clk(clk), .rst(rst), .boot(boot), .cpu_valid(cpu_valid), .cpu_instr(cpu_instr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .m_valid(m_valid), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready),
    .err(err), .err_code(err_code), .err_clr(err_clr)
  );

  iob_cpu_bus_split #(.N_SLAVES(3), .SEL_W(2), .TIMEOUT_W(4)) dut_b (
    .clk(clk), .rst(rst), .boot(b_boot), .cpu_valid(b_cpu_valid), .cpu_instr(b_cpu_instr),
    .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata), .cpu_wstrb(b_cpu_wstrb),
    .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready), .m_valid(b_m_valid), .m_addr(b_m_addr),
    .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb), .m_rdata(b_m_rdata), .m_ready(b_m_ready),
    .err(b_err), .err_code(b_err_code), .err_clr(b_err_clr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        boot;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;      // cycles from m_valid to m_ready; -1 = never
    logic [31:0] d0;
    logic [31:0] d1;
    logic        noise;    // other slave asserts m_ready in the m_valid cycle
    logic        drop;     // cpu_valid released right after m_valid
    logic        clr;      // err_clr on the edge that produces the response
    logic [1:0]  exp_mv;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [1:0]  exp_code;
    int          exp_cyc;  // cpu_valid drive -> cpu_ready, in cycles
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  code;
  } exp_t;

  exp_t sb[$];
  vec_t vecs [9];

  // Scoreboard: every cpu_ready pulse consumes one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (cpu_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_depth", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("cpu_rdata", cpu_rdata, e.rdata);
        chk("err_at_resp", {29'd0, err, err_code}, {29'd0, e.err, e.code});
      end
    end
  end

  task automatic run_txn(input vec_t v);
    int cyc;
    int mv_cyc;
    int mv_cnt;
    @(negedge clk);
    boot      = v.boot;
    cpu_instr = v.instr;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    cpu_wstrb = v.wstrb;
    m_rdata   = {v.d1, v.d0};
    cpu_valid = 1'b1;
    sb.push_back('{v.exp_rdata, v.exp_err, v.exp_code});
    cyc = 0;
    mv_cyc = -1;
    mv_cnt = 0;
    while (cpu_ready !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      m_ready = 2'b00;
      err_clr = 1'b0;
      if (m_valid != 2'b00) begin
        mv_cnt++;
        if (mv_cnt == 1) begin
          mv_cyc = cyc;
          chk("m_valid", {30'd0, m_valid}, {30'd0, v.exp_mv});
          chk("m_addr", m_addr, v.addr);
          chk("m_wdata", m_wdata, v.wdata);
          chk("m_wstrb", {28'd0, m_wstrb}, {28'd0, v.wstrb});
          if (v.noise) m_ready = ~v.exp_mv;
          if (v.drop) cpu_valid = 1'b0;
        end
      end
      if (mv_cyc >= 0 && v.lat >= 0 && cyc == mv_cyc + v.lat) m_ready = v.exp_mv;
      if (v.clr && cyc == v.exp_cyc - 1) err_clr = 1'b1;
    end
    chk("latency", 32'(cyc), 32'(v.exp_cyc));
    chk("m_valid_pulses", 32'(mv_cnt), (v.exp_mv != 2'b00) ? 32'd1 : 32'd0);
    cpu_valid = 1'b0;
    m_ready   = 2'b00;
    err_clr   = 1'b0;
    @(negedge clk);
    chk("cpu_ready_width", {31'd0, cpu_ready}, 32'd0);
    if (v.exp_err) begin
      chk("err_sticky", {29'd0, err, err_code}, {29'd0, 1'b1, v.exp_code});
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_cleared", {29'd0, err, err_code}, 32'd0);
    end
  endtask

  task automatic b_txn(input logic [31:0] addr, input logic [2:0] exp_mv,
                       input logic [1:0] exp_code, input logic [31:0] exp_rdata);
    int cyc;
    int mvs;
    @(negedge clk);
    b_cpu_addr  = addr;
    b_cpu_valid = 1'b1;
    cyc = 0;
    mvs = 0;
    while (b_cpu_ready !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      b_m_ready = 3'b000;
      if (b_m_valid != 3'b000) begin
        mvs++;
        chk("b_m_valid", {29'd0, b_m_valid}, {29'd0, exp_mv});
        b_m_ready = b_m_valid;
      end
    end
    chk("b_latency", 32'(cyc), 32'd2);
    chk("b_m_valid_pulses", 32'(mvs), (exp_mv != 3'b000) ? 32'd1 : 32'd0);
    chk("b_cpu_rdata", b_cpu_rdata, exp_rdata);
    chk("b_err_code", {30'd0, b_err_code}, {30'd0, exp_code});
    b_cpu_valid = 1'b0;
    b_m_ready   = 3'b000;
    @(negedge clk);
    b_err_clr = 1'b1;
    @(negedge clk);
    b_err_clr = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int quiet;
    vecs[0] = '{1'b0, 1'b0, 32'h00000010, 32'h0, 4'b0000, 3, 32'hCAFE0001, 32'hBEEF0001,
                1'b1, 1'b0, 1'b0, 2'b01, 32'hCAFE0001, 1'b0, 2'd0, 5};
    vecs[1] = '{1'b1, 1'b1, 32'h00000000, 32'h0, 4'b0000, 1, 32'h11110000, 32'h22220000,
                1'b0, 1'b0, 1'b0, 2'b10, 32'h22220000, 1'b0, 2'd0, 3};
    vecs[2] = '{1'b0, 1'b1, 32'h00000000, 32'h0, 4'b0000, 0, 32'h11110000, 32'h22220000,
                1'b0, 1'b0, 1'b0, 2'b01, 32'h11110000, 1'b0, 2'd0, 2};
    vecs[3] = '{1'b0, 1'b0, 32'h80000004, 32'hA5A55A5A, 4'b0011, 0, 32'h0, 32'h00000D1D,
                1'b0, 1'b0, 1'b0, 2'b10, 32'h00000D1D, 1'b0, 2'd0, 2};
    vecs[4] = '{1'b1, 1'b0, 32'h00000020, 32'h0, 4'b0000, 2, 32'h33330000, 32'h44440000,
                1'b0, 1'b0, 1'b0, 2'b01, 32'h33330000, 1'b0, 2'd0, 4};
    vecs[5] = '{1'b0, 1'b0, 32'h80001000, 32'h0BADF00D, 4'b1111, 5, 32'h0, 32'h5555AAAA,
                1'b0, 1'b1, 1'b0, 2'b10, 32'h5555AAAA, 1'b0, 2'd0, 7};
    vecs[6] = '{1'b0, 1'b0, 32'h00000040, 32'h0, 4'b0000, -1, 32'h1, 32'h2,
                1'b0, 1'b0, 1'b0, 2'b01, 32'hFFFFFFFF, 1'b1, 2'd2, 257};
    vecs[7] = '{1'b0, 1'b0, 32'h00000048, 32'h0, 4'b0000, 255, 32'h77771234, 32'h2,
                1'b0, 1'b0, 1'b0, 2'b01, 32'h77771234, 1'b0, 2'd0, 257};
    vecs[8] = '{1'b0, 1'b0, 32'h0000004C, 32'h0, 4'b0000, -1, 32'h1, 32'h2,
                1'b0, 1'b0, 1'b1, 2'b01, 32'hFFFFFFFF, 1'b0, 2'd0, 257};

    rst = 1'b1;
    boot = 1'b0; cpu_valid = 1'b0; cpu_instr = 1'b0; err_clr = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0; m_rdata = '0; m_ready = '0;
    b_boot = 1'b0; b_cpu_valid = 1'b0; b_cpu_instr = 1'b0; b_err_clr = 1'b0;
    b_cpu_addr = '0; b_cpu_wdata = '0; b_cpu_wstrb = '0; b_m_ready = '0;
    b_m_rdata = {32'h0000C2C2, 32'h0000B1B1, 32'h0000A0A0};
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_m_valid", {30'd0, m_valid}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_err", {29'd0, err, err_code}, 32'd0);
    chk("rst_b_m_valid", {29'd0, b_m_valid}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Three-slave instance: valid slaves and the unmapped fourth region.
    b_txn(32'h80000000, 3'b100, 2'd0, 32'h0000C2C2);
    b_txn(32'h40000000, 3'b010, 2'd0, 32'h0000B1B1);
    b_txn(32'hC0000000, 3'b000, 2'd1, 32'hFFFFFFFF);

    // Reset while a request is parked in WAIT.
    @(negedge clk);
    cpu_addr = 32'h00000044; cpu_wdata = 32'h55550000; cpu_wstrb = 4'b0000;
    boot = 1'b0; cpu_instr = 1'b0; cpu_valid = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_m_addr", m_addr, 32'h00000044);
    rst = 1'b1;
    #1;
    chk("mid_rst_outputs", {m_addr | m_wdata | cpu_rdata},  32'd0);
    chk("mid_rst_flags", {25'd0, cpu_ready, m_valid, m_wstrb}, 32'd0);
    chk("mid_rst_err", {29'd0, err, err_code}, 32'd0);
    cpu_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_ready = 2'b01;
    quiet = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m_ready = 2'b00;
      if (cpu_ready !== 1'b0 || m_valid !== 2'b00) quiet++;
    end
    chk("late_m_ready_ignored", 32'(quiet), 32'd0);
    run_txn(vecs[0]);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
